// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StStall = 2'b01,
        StFlush = 2'b10,
        StHold  = 2'b11
    } state_e;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller; master drives the pipe state,
// slave (the controller) returns enables, forwarding selects and event counters.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rt;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic              ex_mem_read_en;
    logic              ex_redirect;
    logic [REG_AW-1:0] mem_dest;
    logic              mem_reg_write_en;
    logic [REG_AW-1:0] wb_dest;
    logic              wb_reg_write_en;
    logic              ext_stall;

    logic              pc_load_en;
    logic              if_id_load_en;
    logic              if_id_flush;
    logic              id_ex_load_en;
    logic              id_ex_bubble;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              hold_timeout;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_mem_read_en, ex_redirect,
               mem_dest, mem_reg_write_en, wb_dest, wb_reg_write_en, ext_stall,
        input  pc_load_en, if_id_load_en, if_id_flush, id_ex_load_en, id_ex_bubble,
               fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt, hold_timeout
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_mem_read_en, ex_redirect,
               mem_dest, mem_reg_write_en, wb_dest, wb_reg_write_en, ext_stall,
        output pc_load_en, if_id_load_en, if_id_flush, id_ex_load_en, id_ex_bubble,
               fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt, hold_timeout
    );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational ALU operand forwarding select for one source register.
module pipe_hazard_ctrl_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [REG_AW-1:0] mem_dest_i,
    input  logic              mem_we_i,
    input  logic [REG_AW-1:0] wb_dest_i,
    input  logic              wb_we_i,
    output logic [1:0]        sel_o
);

    // The younger EX/MEM result shadows MEM/WB; $0 is hardwired and never forwarded.
    always_comb begin
        sel_o = FWD_REG;
        if (mem_we_i && (mem_dest_i != '0) && (mem_dest_i == src_i)) begin
            sel_o = FWD_EXMEM;
        end else if (wb_we_i && (wb_dest_i != '0) && (wb_dest_i == src_i)) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, redirect flush, external freeze,
// operand forwarding, saturating event counters and a sticky hold watchdog.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned HOLD_MAX = 255
) (
    input logic          clk,
    input logic          rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int unsigned HoldW = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_MAX);

    state_e           state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic luse;
    logic pc_en, ifid_en, ifid_flush, idex_en, bubble;
    logic stall_inc, flush_inc;

    // In STALL the load has already moved past EX (bubble loaded), so a load stalls once only.
    assign luse = bus.ex_mem_read_en && (state_q != StStall) && (bus.ex_rt != '0) &&
                  ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

    always_comb begin
        state_d    = StRun;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        bubble     = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (!rst) begin
            state_d = StRun;
        end else if (bus.ext_stall) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            state_d = StHold;
        end else if (bus.ex_redirect) begin
            ifid_flush = 1'b1;
            bubble     = 1'b1;
            flush_inc  = 1'b1;
            state_d    = StFlush;
        end else if (luse) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            bubble    = 1'b1;
            stall_inc = 1'b1;
            state_d   = StStall;
        end
    end

    always_comb begin
        hold_d    = '0;
        timeout_d = timeout_q;
        stall_d   = stall_q;
        flush_d   = flush_q;
        if (bus.ext_stall) begin
            hold_d = (hold_q == HoldMax) ? hold_q : hold_q + HoldW'(1);
            if (hold_q == HoldMax) begin
                timeout_d = 1'b1;
            end
        end
        if (stall_inc && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (flush_inc && (flush_q != '1)) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StRun;
            hold_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    assign bus.pc_load_en    = pc_en;
    assign bus.if_id_load_en = ifid_en;
    assign bus.if_id_flush   = ifid_flush;
    assign bus.id_ex_load_en = idex_en;
    assign bus.id_ex_bubble  = bubble;
    assign bus.stall_cnt     = stall_q;
    assign bus.flush_cnt     = flush_q;
    assign bus.hold_timeout  = timeout_q;

    pipe_hazard_ctrl_fwd_unit #(
        .REG_AW (REG_AW)
    ) u_fwd_a (
        .src_i      (bus.ex_rs),
        .mem_dest_i (bus.mem_dest),
        .mem_we_i   (bus.mem_reg_write_en),
        .wb_dest_i  (bus.wb_dest),
        .wb_we_i    (bus.wb_reg_write_en),
        .sel_o      (bus.fwd_a_sel)
    );

    pipe_hazard_ctrl_fwd_unit #(
        .REG_AW (REG_AW)
    ) u_fwd_b (
        .src_i      (bus.ex_rt),
        .mem_dest_i (bus.mem_dest),
        .mem_we_i   (bus.mem_reg_write_en),
        .wb_dest_i  (bus.wb_dest),
        .wb_we_i    (bus.wb_reg_write_en),
        .sel_o      (bus.fwd_b_sel)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; narrow counters expose saturation.
module tb_pipe_hazard_ctrl;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned HOLD_MAX = 255;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .REG_AW   (REG_AW),
        .CNT_W    (CNT_W),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_load_en, if_id_load_en, if_id_flush, id_ex_load_en, id_ex_bubble}
    function automatic logic [4:0] ctl();
        return {bus.pc_load_en, bus.if_id_load_en, bus.if_id_flush,
                bus.id_ex_load_en, bus.id_ex_bubble};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.id_rs            = '0;
        bus.id_rt            = '0;
        bus.id_uses_rt       = 1'b0;
        bus.ex_rs            = '0;
        bus.ex_rt            = '0;
        bus.ex_mem_read_en   = 1'b0;
        bus.ex_redirect      = 1'b0;
        bus.mem_dest         = '0;
        bus.mem_reg_write_en = 1'b0;
        bus.wb_dest          = '0;
        bus.wb_reg_write_en  = 1'b0;
        bus.ext_stall        = 1'b0;
    endtask

    // lw $2 in EX, add $3,$2,$4 in ID
    task automatic set_luse();
        bus.ex_mem_read_en = 1'b1;
        bus.ex_rt          = 5'd2;
        bus.id_rs          = 5'd2;
        bus.id_rt          = 5'd4;
        bus.id_uses_rt     = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        clr();
        #2;
        chk("rst_ctl", 16'(ctl()), 16'(5'b11010));
        chk("rst_stall_cnt", 16'(bus.stall_cnt), 16'd0);
        chk("rst_flush_cnt", 16'(bus.flush_cnt), 16'd0);
        chk("rst_timeout", 16'(bus.hold_timeout), 16'd0);
        set_luse();
        #1;
        chk("rst_ctl_luse", 16'(ctl()), 16'(5'b11010));
        clr();
        tick();
        rst = 1'b1;
        #1;
        chk("idle_ctl", 16'(ctl()), 16'(5'b11010));
        chk("idle_fwd", 16'({bus.fwd_a_sel, bus.fwd_b_sel}), 16'd0);

        // Load-use stalls exactly one cycle even with inputs held.
        set_luse();
        #1;
        chk("luse_ctl", 16'(ctl()), 16'(5'b00011));
        tick();
        chk("luse_stall_cnt", 16'(bus.stall_cnt), 16'd1);
        chk("luse_second_cycle_ctl", 16'(ctl()), 16'(5'b11010));
        tick();
        chk("luse_stall_cnt_hold", 16'(bus.stall_cnt), 16'd1);
        clr();

        // lw $0: never a hazard.
        bus.ex_mem_read_en = 1'b1;
        #1;
        chk("lw_r0_ctl", 16'(ctl()), 16'(5'b11010));
        tick();
        chk("lw_r0_stall_cnt", 16'(bus.stall_cnt), 16'd1);

        // sw: rt match only counts when id_uses_rt.
        bus.ex_rt      = 5'd7;
        bus.id_rs      = 5'd3;
        bus.id_rt      = 5'd7;
        bus.id_uses_rt = 1'b0;
        #1;
        chk("rt_unused_ctl", 16'(ctl()), 16'(5'b11010));
        bus.id_uses_rt = 1'b1;
        #1;
        chk("sw_luse_ctl", 16'(ctl()), 16'(5'b00011));
        tick();
        chk("sw_stall_cnt", 16'(bus.stall_cnt), 16'd2);
        clr();

        // Redirect beats a coincident load-use.
        set_luse();
        bus.ex_redirect = 1'b1;
        #1;
        chk("redirect_ctl", 16'(ctl()), 16'(5'b11111));
        tick();
        chk("redirect_flush_cnt", 16'(bus.flush_cnt), 16'd1);
        chk("redirect_stall_cnt", 16'(bus.stall_cnt), 16'd2);
        clr();
        #1;
        chk("after_flush_ctl", 16'(ctl()), 16'(5'b11010));

        // Forwarding priority and $0 exclusion.
        bus.ex_rs            = 5'd5;
        bus.ex_rt            = 5'd5;
        bus.mem_dest         = 5'd5;
        bus.wb_dest          = 5'd5;
        bus.mem_reg_write_en = 1'b1;
        bus.wb_reg_write_en  = 1'b1;
        #1;
        chk("fwd_exmem", 16'({bus.fwd_a_sel, bus.fwd_b_sel}), 16'(4'b0101));
        bus.mem_reg_write_en = 1'b0;
        #1;
        chk("fwd_memwb", 16'({bus.fwd_a_sel, bus.fwd_b_sel}), 16'(4'b1010));
        bus.mem_reg_write_en = 1'b1;
        bus.ex_rs            = 5'd0;
        bus.ex_rt            = 5'd0;
        bus.mem_dest         = 5'd0;
        bus.wb_dest          = 5'd0;
        #1;
        chk("fwd_r0", 16'({bus.fwd_a_sel, bus.fwd_b_sel}), 16'd0);
        bus.ex_rt    = 5'd9;
        bus.mem_dest = 5'd9;
        bus.wb_dest  = 5'd9;
        #1;
        chk("fwd_b_only", 16'({bus.fwd_a_sel, bus.fwd_b_sel}), 16'(4'b0001));
        clr();

        // Held load-use alternates STALL/RUN: 8 more stalls saturate the 3-bit counter at 7.
        set_luse();
        for (int i = 0; i < 16; i++) begin
            tick();
        end
        chk("stall_cnt_saturate", 16'(bus.stall_cnt), 16'd7);
        clr();

        // External freeze for HOLD_MAX+1 cycles with a pending load-use.
        set_luse();
        bus.ext_stall = 1'b1;
        for (int i = 0; i < 256; i++) begin
            #1;
            chk("hold_ctl", 16'(ctl()), 16'(5'b00000));
            if (i == 255) begin
                chk("hold_timeout_pre", 16'(bus.hold_timeout), 16'd0);
            end
            tick();
        end
        chk("hold_timeout_set", 16'(bus.hold_timeout), 16'd1);
        bus.ext_stall = 1'b0;
        #1;
        chk("hold_release_luse_ctl", 16'(ctl()), 16'(5'b00011));
        tick();
        clr();
        tick();
        chk("hold_timeout_sticky", 16'(bus.hold_timeout), 16'd1);

        bus.ex_redirect = 1'b1;
        #1;
        tick();
        chk("flush_cnt_2", 16'(bus.flush_cnt), 16'd2);
        clr();

        // Async reset while in STALL, no clock edge involved.
        set_luse();
        #1;
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_stall_cnt", 16'(bus.stall_cnt), 16'd0);
        chk("async_rst_flush_cnt", 16'(bus.flush_cnt), 16'd0);
        chk("async_rst_timeout", 16'(bus.hold_timeout), 16'd0);
        chk("async_rst_ctl", 16'(ctl()), 16'(5'b11010));
        #1;
        rst = 1'b1;
        #1;
        chk("post_rst_state_run", 16'(ctl()), 16'(5'b00011));
        clr();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
